// File: rtl/ej_1_pkg.sv
// Shared types and defaults for the ej_1 serial run-length detector.
package ej_1_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ONES,
        ZEROS
    } state_t;

    localparam int RUN_LEN_DEF = 3;

endpackage

// File: rtl/ej_1_run_detector.sv
// Moore run-length detector: Z flags a run of >= RUN_LEN ones, S a run of >= RUN_LEN zeros.
// Both flags are registered and derived only from the next state and count.
module ej_1_run_detector
    import ej_1_pkg::*;
#(
    parameter int RUN_LEN = RUN_LEN_DEF
) (
    input  logic clk,
    input  logic RESET,
    input  logic X,
    output logic Z,
    output logic S
);

    localparam int CW = $clog2(RUN_LEN + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(RUN_LEN);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          z_q, z_d;
    logic          s_q, s_d;
    logic [CW-1:0] cnt_sat;

    // Counter holds at RUN_LEN so an arbitrarily long run keeps its flag up.
    assign cnt_sat = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = X ? ONES : ZEROS;
                cnt_d   = CNT_ONE;
            end
            ONES: begin
                if (X) begin
                    cnt_d = cnt_sat;
                end else begin
                    state_d = ZEROS;
                    cnt_d   = CNT_ONE;
                end
            end
            ZEROS: begin
                if (!X) begin
                    cnt_d = cnt_sat;
                end else begin
                    state_d = ONES;
                    cnt_d   = CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        z_d = (state_d == ONES)  && (cnt_d == CNT_MAX);
        s_d = (state_d == ZEROS) && (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            z_q     <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            s_q     <= s_d;
        end
    end

    assign Z = z_q;
    assign S = s_q;

endmodule

// File: tb/tb_ej_1_run_detector.sv
// Self-checking bench for ej_1_run_detector: directed vector table, hand-written
// reset/interrupted-run sequences and biased random runs against a bit-history model.
module tb_ej_1_run_detector;

    localparam int RUN_LEN = 3;

    typedef struct {
        logic x;
        logic expZ;
        logic expS;
    } vec_t;

    logic clk;
    logic RESET;
    logic X;
    logic Z;
    logic S;

    int   checks;
    int   failures;
    logic hist[$];
    vec_t vecs[$];

    ej_1_run_detector #(.RUN_LEN(RUN_LEN)) dut (
        .clk   (clk),
        .RESET (RESET),
        .X     (X),
        .Z     (Z),
        .S     (S)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // True when the last RUN_LEN bits sampled since reset all equal val.
    function automatic logic modelFlag(input logic val);
        if (hist.size() < RUN_LEN) return 1'b0;
        for (int k = 0; k < RUN_LEN; k++) begin
            if (hist[hist.size() - 1 - k] !== val) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic compareBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput(input string name, input logic expZ, input logic expS);
        compareBit({name, ".Z"}, Z, expZ);
        compareBit({name, ".S"}, S, expS);
    endtask

    task automatic checkModel(input string name);
        compareBit({name, ".modelZ"}, Z, modelFlag(1'b1));
        compareBit({name, ".modelS"}, S, modelFlag(1'b0));
        compareBit({name, ".excl"}, Z & S, 1'b0);
    endtask

    task automatic applyStimulus(input logic b);
        X = b;
        @(posedge clk);
        hist.push_back(b);
        #1;
    endtask

    task automatic addVec(input logic x, input logic z, input logic s);
        vec_t v;
        v.x = x;
        v.expZ = z;
        v.expS = s;
        vecs.push_back(v);
    endtask

    initial begin
        int toggle;
        logic b;
        checks   = 0;
        failures = 0;

        // Five 1s, three 0s, seven 1s, then ten alternating bits starting with 0.
        addVec(1, 0, 0); addVec(1, 0, 0); addVec(1, 1, 0); addVec(1, 1, 0); addVec(1, 1, 0);
        addVec(0, 0, 0); addVec(0, 0, 0); addVec(0, 0, 1);
        addVec(1, 0, 0); addVec(1, 0, 0); addVec(1, 1, 0); addVec(1, 1, 0);
        addVec(1, 1, 0); addVec(1, 1, 0); addVec(1, 1, 0);
        for (int i = 0; i < 10; i++) addVec(logic'(i % 2), 0, 0);

        RESET = 1'b1;
        X     = 1'b0;
        #1;
        checkOutput("resetInit", 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            X = ~X;
            @(posedge clk);
            #1;
            checkOutput($sformatf("resetHold%0d", i), 1'b0, 1'b0);
            X = 1'bx;
        end
        @(negedge clk);
        RESET = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].x);
            checkOutput($sformatf("vec%0d", i), vecs[i].expZ, vecs[i].expS);
            checkModel($sformatf("vec%0d", i));
        end

        // Reset in the middle of a run of 1s must drop Z without a clock edge.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1);
        checkOutput("preResetOnes", 1'b1, 1'b0);
        #2 RESET = 1'b1;
        #1 checkOutput("asyncResetOnes", 1'b0, 1'b0);
        X = 1'bx;
        @(posedge clk);
        #1 checkOutput("resetEdgeIgnored", 1'b0, 1'b0);
        @(negedge clk);
        RESET = 1'b0;
        hist.delete();

        // Same for a run of 0s and S.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0);
        checkOutput("preResetZeros", 1'b0, 1'b1);
        #3 RESET = 1'b1;
        #1 checkOutput("asyncResetZeros", 1'b0, 1'b0);
        @(negedge clk);
        RESET = 1'b0;
        hist.delete();

        // Interrupted run: 1,1,0,1,1,1 from IDLE -> Z only after the sixth edge.
        applyStimulus(1'b1); checkOutput("intr0", 1'b0, 1'b0);
        applyStimulus(1'b1); checkOutput("intr1", 1'b0, 1'b0);
        applyStimulus(1'b0); checkOutput("intr2", 1'b0, 1'b0);
        applyStimulus(1'b1); checkOutput("intr3", 1'b0, 1'b0);
        applyStimulus(1'b1); checkOutput("intr4", 1'b0, 1'b0);
        applyStimulus(1'b1); checkOutput("intr5", 1'b1, 1'b0);

        // Biased random stream so long runs of both polarities appear.
        b = 1'b0;
        for (int i = 0; i < 300; i++) begin
            toggle = int'($urandom_range(0, 3));
            if (toggle == 0) b = ~b;
            applyStimulus(b);
            checkModel($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
